// File: rtl/color_pkg.sv
// Shared definitions for the colour sequencer and its button front end.
package color_pkg;

   // Default width of the colour code bus.
   localparam int unsigned DEFAULT_CODE_W = 32'd4;

   // Colour codes understood by the downstream display/LED decoder.
   localparam logic [3:0] RED     = 4'd2;
   localparam logic [3:0] CYAN    = 4'd3;
   localparam logic [3:0] YELLOW  = 4'd4;
   localparam logic [3:0] MAGENTA = 4'd5;

   // Debounced button state.
   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } deb_state_t;

   // Width of a counter that must hold 0..limit-1; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned limit);
      if (limit > 32'd1) begin
         return $clog2(limit);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser followed by a counting debouncer.
// Emits a one-cycle pulse on each accepted press and the accepted level.
module btn_debounce
   import color_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000
)
(
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press,
   output logic o_level
);

   localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

   logic             r_sync1;
   logic             r_sync2;
   deb_state_t       r_state;
   deb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_press;
   logic             w_press_nxt;

   // Bring the raw button into the clock domain; only the second flop is used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce state, stability counter and press pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RELEASED;
         r_cnt   <= {CNT_W{1'b0}};
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_press <= w_press_nxt;
      end
   end

   // Flip the accepted level only after the input has disagreed for the full window.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press_nxt = 1'b0;
      case (r_state)
         RELEASED: begin
            if (r_sync2) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = PRESSED;
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_press_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end else begin
               w_cnt_nxt = {CNT_W{1'b0}};
            end
         end
         PRESSED: begin
            if (!r_sync2) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = RELEASED;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end else begin
               w_cnt_nxt = {CNT_W{1'b0}};
            end
         end
         default: begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   assign o_press = r_press;
   assign o_level = (r_state == PRESSED);

endmodule

// File: rtl/color_sequencer.sv
// Colour-code sequencer: steps a code through FIRST_CODE..LAST_CODE on a
// debounced button press or on a periodic auto tick, ascending or descending,
// with a hold input that freezes both the colour and the auto timer.
module color_sequencer
   import color_pkg::*;
#(
   parameter int unsigned CODE_W          = DEFAULT_CODE_W,
   parameter int unsigned FIRST_CODE      = 32'(RED),
   parameter int unsigned LAST_CODE       = 32'(MAGENTA),
   parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
   parameter int unsigned AUTO_PERIOD     = 32'd100_000_000
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_continue_btn,
   input  logic              i_auto_mode,
   input  logic              i_dir,
   input  logic              i_hold,
   output logic [CODE_W-1:0] o_color,
   output logic              o_step,
   output logic              o_wrap
);

   localparam logic [CODE_W-1:0]  C_FIRST = CODE_W'(FIRST_CODE);
   localparam logic [CODE_W-1:0]  C_LAST  = CODE_W'(LAST_CODE);
   localparam int unsigned        TIMER_W = cnt_width(AUTO_PERIOD);
   localparam logic [TIMER_W-1:0] T_LAST  = TIMER_W'(AUTO_PERIOD - 32'd1);

   logic               w_press;
   logic               w_level_unused;
   logic [TIMER_W-1:0] r_timer;
   logic               r_tick;
   logic               w_req;
   logic [CODE_W-1:0]  w_color_nxt;
   logic               w_wrap_nxt;
   logic [CODE_W-1:0]  r_color;
   logic               r_step;
   logic               r_wrap;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_continue_btn),
      .o_press (w_press),
      .o_level (w_level_unused)
   );

   // Auto timer: free-runs in auto mode, freezes on hold, clears when auto is off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= {TIMER_W{1'b0}};
         r_tick  <= 1'b0;
      end else if (!i_auto_mode) begin
         r_timer <= {TIMER_W{1'b0}};
         r_tick  <= 1'b0;
      end else if (i_hold) begin
         r_timer <= r_timer;
         r_tick  <= 1'b0;
      end else if (r_timer == T_LAST) begin
         r_timer <= {TIMER_W{1'b0}};
         r_tick  <= 1'b1;
      end else begin
         r_timer <= r_timer + TIMER_W'(1);
         r_tick  <= 1'b0;
      end
   end

   // A press and a tick in the same cycle merge into one request; hold discards both.
   assign w_req = (w_press | r_tick) & ~i_hold;

   // Next colour in the selected direction; out-of-range codes recover to the start end.
   always_comb begin
      w_color_nxt = r_color;
      w_wrap_nxt  = 1'b0;
      if (i_dir == 1'b0) begin
         if ((r_color < C_FIRST) || (r_color >= C_LAST)) begin
            w_color_nxt = C_FIRST;
            w_wrap_nxt  = 1'b1;
         end else begin
            w_color_nxt = r_color + CODE_W'(1);
            w_wrap_nxt  = 1'b0;
         end
      end else begin
         if ((r_color <= C_FIRST) || (r_color > C_LAST)) begin
            w_color_nxt = C_LAST;
            w_wrap_nxt  = 1'b1;
         end else begin
            w_color_nxt = r_color - CODE_W'(1);
            w_wrap_nxt  = 1'b0;
         end
      end
   end

   // Colour register with its step and wrap pulses, updated only on a request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_color <= C_FIRST;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (w_req) begin
         r_color <= w_color_nxt;
         r_step  <= 1'b1;
         r_wrap  <= w_wrap_nxt;
      end else begin
         r_color <= r_color;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end
   end

   assign o_color = r_color;
   assign o_step  = r_step;
   assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_color_sequencer.sv
// Self-checking bench for color_sequencer with short debounce and auto periods.
// A behavioural model predicts color/step/wrap every cycle; directed checks
// pin step counts and colours at the end of each scenario.
module tb_color_sequencer;

   localparam int DEB = 4;
   localparam int PER = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       auto_m;
   logic       dir_m;
   logic       hold_m;
   logic [3:0] color;
   logic       step;
   logic       wrap;

   color_sequencer #(
      .CODE_W          (4),
      .FIRST_CODE      (2),
      .LAST_CODE       (5),
      .DEBOUNCE_CYCLES (DEB),
      .AUTO_PERIOD     (PER)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_continue_btn (btn),
      .i_auto_mode    (auto_m),
      .i_dir          (dir_m),
      .i_hold         (hold_m),
      .o_color        (color),
      .o_step         (step),
      .o_wrap         (wrap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int tot_step = 0;
   int tot_wrap = 0;
   bit done = 1'b0;

   // Model state: the sequence as a list, position in it, and event history.
   int seq [4] = '{2, 3, 4, 5};
   int m_idx;
   bit m_s1, m_s2;
   bit m_level;
   int m_run;
   int m_phase;
   bit m_press, m_tick;
   bit m_step, m_wrap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_phase = 0;
      m_press = 0; m_tick = 0; m_step = 0; m_wrap = 0;
   endtask

   // One clock of the model: a request moves one place along the list (circularly);
   // a press is the 4th consecutive synchronised cycle disagreeing with the level;
   // a tick fires on every PER-th active (auto, not held) cycle.
   task automatic model_step();
      bit req, n_press, n_tick, n_wrap;
      req = (m_press || m_tick) && !hold_m;
      n_wrap = 0;
      if (req) begin
         if (!dir_m) begin
            n_wrap = (m_idx == 3);
            m_idx = (m_idx + 1) % 4;
         end else begin
            n_wrap = (m_idx == 0);
            m_idx = (m_idx + 3) % 4;
         end
      end
      n_press = 0;
      if (m_s2 != m_level) begin
         m_run++;
         if (m_run == DEB) begin
            m_level = !m_level;
            m_run = 0;
            n_press = m_level;
         end
      end else begin
         m_run = 0;
      end
      n_tick = 0;
      if (!auto_m) begin
         m_phase = 0;
      end else if (!hold_m) begin
         m_phase++;
         if (m_phase == PER) begin
            m_phase = 0;
            n_tick = 1;
         end
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_press = n_press;
      m_tick = n_tick;
      m_step = req;
      m_wrap = n_wrap;
   endtask

   task automatic monitor();
      while (!done) begin
         @(posedge clk);
         if (rst) model_reset();
         else model_step();
         #1;
         check("color", 32'(color), 32'(seq[m_idx]));
         check("step", 32'(step), 32'(m_step));
         check("wrap", 32'(wrap), 32'(m_wrap));
         if (step === 1'b1) tot_step++;
         if (wrap === 1'b1) tot_wrap++;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic stimulus();
      int base_s, base_w;
      int exp_man [5];
      exp_man = '{3, 4, 5, 2, 3};
      rst = 1'b0; btn = 1'b0; auto_m = 1'b0; dir_m = 1'b0; hold_m = 1'b0;
      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_color", 32'(color), 32'd2);
      check("rst_step", 32'(step), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      cycles(3);
      rst = 1'b0;
      cycles(2);

      // Manual ascending: five clean presses.
      base_s = tot_step; base_w = tot_wrap;
      for (int i = 0; i < 5; i++) begin
         btn = 1'b1; cycles(20);
         btn = 1'b0; cycles(20);
         check("manual_color", 32'(color), 32'(exp_man[i]));
      end
      check("manual_steps", 32'(tot_step - base_s), 32'd5);
      check("manual_wraps", 32'(tot_wrap - base_w), 32'd1);

      // Reset between edges takes effect immediately.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midclk_rst_color", 32'(color), 32'd2);
      cycles(2);
      rst = 1'b0;
      cycles(2);

      // Bounce: toggle every 2 cycles, then hold high.
      base_s = tot_step;
      for (int i = 0; i < 15; i++) begin
         btn = (i % 2 == 0);
         cycles(2);
      end
      btn = 1'b1; cycles(20);
      btn = 1'b0; cycles(20);
      check("bounce_steps", 32'(tot_step - base_s), 32'd1);
      check("bounce_color", 32'(color), 32'd3);

      // A 3-cycle glitch is shorter than the window.
      base_s = tot_step;
      btn = 1'b1; cycles(3);
      btn = 1'b0; cycles(20);
      check("glitch_steps", 32'(tot_step - base_s), 32'd0);
      check("glitch_color", 32'(color), 32'd3);

      // Auto descending from 2: 5,4,3,2,5.
      rst = 1'b1; cycles(1);
      rst = 1'b0; auto_m = 1'b1; dir_m = 1'b1;
      base_s = tot_step; base_w = tot_wrap;
      cycles(52);
      check("auto_steps", 32'(tot_step - base_s), 32'd5);
      check("auto_wraps", 32'(tot_wrap - base_w), 32'd2);
      check("auto_color", 32'(color), 32'd5);
      // Hold freezes the timer at count 2; 8 more cycles to the next tick.
      hold_m = 1'b1;
      base_s = tot_step;
      cycles(25);
      check("hold_steps", 32'(tot_step - base_s), 32'd0);
      check("hold_color", 32'(color), 32'd5);
      hold_m = 1'b0;
      cycles(8);
      check("resume_early_steps", 32'(tot_step - base_s), 32'd0);
      cycles(1);
      check("resume_steps", 32'(tot_step - base_s), 32'd1);
      check("resume_color", 32'(color), 32'd4);
      auto_m = 1'b0; dir_m = 1'b0;
      cycles(5);

      // Press and tick registered on the same edge give a single step.
      rst = 1'b1; cycles(1);
      rst = 1'b0; auto_m = 1'b1; dir_m = 1'b0;
      cycles(4);
      btn = 1'b1;
      base_s = tot_step;
      cycles(15);
      check("simul_steps", 32'(tot_step - base_s), 32'd1);
      check("simul_color", 32'(color), 32'd3);
      auto_m = 1'b0; btn = 1'b0;
      cycles(20);

      // Reset in the middle of a debounce window with the button still held.
      btn = 1'b1;
      cycles(4);
      #2 rst = 1'b1;
      #1;
      check("deb_rst_color", 32'(color), 32'd2);
      cycles(2);
      rst = 1'b0;
      base_s = tot_step;
      cycles(6);
      check("deb_rst_early_steps", 32'(tot_step - base_s), 32'd0);
      cycles(1);
      check("deb_rst_steps", 32'(tot_step - base_s), 32'd1);
      check("deb_rst_color3", 32'(color), 32'd3);
      cycles(20);
      check("deb_rst_held_steps", 32'(tot_step - base_s), 32'd1);
      btn = 1'b0;
      cycles(20);
      done = 1'b1;
   endtask

   initial begin
      model_reset();
      fork
         monitor();
         stimulus();
      join
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
Parametrised colour-code sequencer that steps an output code through a contiguous range FIRST_CODE..LAST_CODE.
- Steps on a debounced continue-button press (manual mode) or on a programmable periodic tick (auto mode), in either direction, with hold.
- Sits between the board buttons/switches and the display/LED colour decoder.
- Replaces the fixed 2..5 free-running counter.

Parameters:
CODE_W, 4, width of colour code output
FIRST_CODE, 2, lowest code in sequence (2=red)
LAST_CODE, 5, highest code in sequence (5=magenta); must satisfy FIRST_CODE < LAST_CODE < 2**CODE_W
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (>=1)
AUTO_PERIOD, 100_000_000, clk cycles between auto-mode steps (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
continue_btn  in  1  raw asynchronous push-button, active-high
auto_mode  in  1  0 = step on button press only; 1 = also step every AUTO_PERIOD cycles
dir  in  1  0 = ascending, 1 = descending
hold  in  1  1 = freeze colour and auto timer; button presses discarded
color  out  CODE_W  current colour code
step  out  1  one-cycle pulse, high in the cycle color takes a new value
wrap  out  1  one-cycle pulse coincident with step when the sequence wrapped

Behaviour:
- Reset values:
  - color = FIRST_CODE; step = 0; wrap = 0.
  - Synchroniser flops = 0; debounced level = 0; debounce count = 0; auto timer = 0.
  - Debounce FSM in RELEASED.
  - Reset is honoured mid-debounce or mid-period; no pending press survives reset.
- Synchroniser: 2-flop chain on continue_btn. Only the second-flop output (btn_s) is used.
- Debounce FSM, states RELEASED and PRESSED:
  - Counter increments each cycle btn_s differs from the FSM level. It clears to 0 on any cycle they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the FSM flips state and the counter clears.
  - A RELEASED->PRESSED flip registers press_pulse (one cycle). A PRESSED->RELEASED flip produces no pulse.
  - A held button yields exactly one press.
- Auto timer:
  - Counts 0..AUTO_PERIOD-1 while auto_mode=1 and hold=0.
  - At AUTO_PERIOD-1 it registers tick_pulse (one cycle) and returns to 0.
  - Clears to 0 whenever auto_mode=0. Frozen (not cleared) while hold=1.
- Step request: req = (press_pulse | tick_pulse) & ~hold. Simultaneous press and tick produce a single step.
- Registered update, on the clock edge where req is high:
  - Ascending: color = (color >= LAST_CODE) ? FIRST_CODE : color+1.
  - Descending: color = (color <= FIRST_CODE) ? LAST_CODE : color-1.
  - Out-of-range recovery: if color < FIRST_CODE or color > LAST_CODE, the next step loads FIRST_CODE (ascending) or LAST_CODE (descending).
  - step is registered alongside and is high the cycle after req.
  - wrap is high with step when the loaded value came from the wrap or recovery branch.
- Latency: a clean button rising edge at cycle 0 gives color change and step visible at cycle 2 + DEBOUNCE_CYCLES + 1 (±1 for input sampling phase). The auto step arrives AUTO_PERIOD cycles after the previous one.
- dir and auto_mode are sampled every cycle. A change takes effect on the next req; no glitch is allowed on color.
- Arithmetic: all code arithmetic is CODE_W bits unsigned. Timer and debounce counters are sized with $clog2 of their limits.

Decomposition:
- Shared package color_pkg:
  - Colour code constants RED=2, CYAN=3, YELLOW=4, MAGENTA=5.
  - Default CODE_W.
  - Debounce state enum {RELEASED, PRESSED}.
- Sub-module btn_debounce (param DEBOUNCE_CYCLES): contains the synchroniser plus the debounce FSM, and outputs press_pulse and level. It is reusable for the other board buttons.
- The auto timer and sequencing logic stay in color_sequencer.

Test Plan:
- Reset/defaults (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10): assert rst mid-clock -> color=2, step=0 and wrap=0 immediately, without waiting for a clock edge.
- Manual ascending: 5 clean presses, each held 20 cycles -> color 3,4,5,2,3. wrap pulses only on the 5->2 step; one step pulse per press.
- Bounce rejection: toggle btn every 2 cycles for 30 cycles, then hold high 20 -> exactly one step, color 2->3. A glitch of 3 cycles alone -> no step.
- Auto descending: auto_mode=1, dir=1 -> step every 10 cycles; color 5,4,3,2,5 starting from 2. wrap pulses on 2->5. Assert hold for 25 cycles -> no step; timer resumes from its frozen count.
- Simultaneous press and tick on the same cycle -> color advances by exactly 1; a single step pulse.
- Reset mid-debounce: press, assert rst at debounce count 2, release rst with btn still high -> exactly one press is accepted after a full DEBOUNCE_CYCLES window from release, color 2->3.
